// File: rtl/jstk_spi_responder_pkg.sv
// jstk_spi_responder_pkg
// Shared constants, state encoding and frame-packing helper for the
// PmodJSTK SPI responder.
//   JSTK_FRAME_BITS  : bits per joystick transfer (5 bytes)
//   JSTK_CMD_PREFIX  : upper six bits of a valid LED command byte
//   JSTK_OFF_*       : MSB position of each byte field in the 40-bit frame
//   jstk_state_t     : responder FSM states
//   jstk_pack_frame  : builds the 40-bit transmit word from the inputs
package jstk_spi_responder_pkg;

  localparam int unsigned JSTK_FRAME_BITS = 40;
  localparam int unsigned JSTK_CNT_W      = 6;
  localparam logic [5:0]  JSTK_CMD_PREFIX = 6'b100000;

  localparam int unsigned JSTK_OFF_X_LO = 39;
  localparam int unsigned JSTK_OFF_X_HI = 31;
  localparam int unsigned JSTK_OFF_Y_LO = 23;
  localparam int unsigned JSTK_OFF_Y_HI = 15;
  localparam int unsigned JSTK_OFF_BTN  = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } jstk_state_t;

  // Byte order on the wire: X low, X high, Y low, Y high, buttons.
  function automatic logic [JSTK_FRAME_BITS-1:0] jstk_pack_frame(
    input logic [9:0] x,
    input logic [9:0] y,
    input logic [2:0] btn
  );
    logic [JSTK_FRAME_BITS-1:0] f;
    f = '0;
    f[JSTK_OFF_X_LO -: 8] = x[7:0];
    f[JSTK_OFF_X_HI -: 8] = {6'b0, x[9:8]};
    f[JSTK_OFF_Y_LO -: 8] = y[7:0];
    f[JSTK_OFF_Y_HI -: 8] = {6'b0, y[9:8]};
    f[JSTK_OFF_BTN  -: 8] = {5'b0, btn};
    return f;
  endfunction

endpackage

// File: rtl/jstk_spi_responder_sync_edge_detect.sv
// sync_edge_detect
// Two-flop synchronizer for an asynchronous pin, a third stage for edge
// detection, and registered rise/fall strobes (3 clk from pin edge).
//   clk, rst : system clock, async active-high reset
//   din      : asynchronous input pin
//   level    : synchronized level, aligned with the strobes
//   rise     : one-cycle strobe on a 0->1 transition
//   fall     : one-cycle strobe on a 1->0 transition
// RST_VAL is the idle level of the pin, so reset never fakes an edge
// while the line sits idle.
module sync_edge_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= RST_VAL;
      s2   <= RST_VAL;
      s3   <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
      fall <= ~s2 & s3;
    end
  end

  assign level = s3;

endmodule

// File: rtl/jstk_spi_responder.sv
// jstk_spi_responder
// Slave side of the PmodJSTK 5-byte SPI transfer (mode 0). Snapshots the
// joystick position and buttons at frame start, shifts them out on MISO
// MSB first, and decodes the LED command from the master's first byte.
//   Clk, Reset  : system clock, async active-high reset
//   SS, SCLK    : slave select (active low) and serial clock, async to Clk
//   MOSI, MISO  : serial data in / out
//   X_Pos/Y_Pos : 10-bit positions, Buttons : {btn2, btn1, btn0}
//   Led         : LED bits from the last valid command byte
//   Cmd_Valid   : pulse when a 100000LL command is latched
//   Frame_Done  : pulse when SS rises after 40 (or more) bits
//   Frame_Error : pulse when SS rises with fewer than 40 bits
module jstk_spi_responder
  import jstk_spi_responder_pkg::*;
#(
  parameter int unsigned SCLK_MAX_DIV = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       SS,
  input  logic       SCLK,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [9:0] X_Pos,
  input  logic [9:0] Y_Pos,
  input  logic [2:0] Buttons,
  output logic [1:0] Led,
  output logic       Cmd_Valid,
  output logic       Frame_Done,
  output logic       Frame_Error
);

  // The synchronizer plus state update consume 4 Clk; a shorter SCLK
  // half-period would let MISO change after the master samples it.
  if (SCLK_MAX_DIV < 4) begin : g_div_check
    $error("SCLK_MAX_DIV must be at least 4");
  end

  logic ss_lvl, ss_rise, ss_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  sync_edge_detect #(.RST_VAL(1'b1)) u_ss (
    .clk(Clk), .rst(Reset), .din(SS),
    .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );

  sync_edge_detect #(.RST_VAL(1'b0)) u_sclk (
    .clk(Clk), .rst(Reset), .din(SCLK),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge_detect #(.RST_VAL(1'b0)) u_mosi (
    .clk(Clk), .rst(Reset), .din(MOSI),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{ss_lvl, sclk_lvl, mosi_rise, mosi_fall};

  jstk_state_t                state;
  logic [JSTK_FRAME_BITS-1:0] tx_sr;
  logic [7:0]                 rx_sr;
  logic [JSTK_CNT_W-1:0]      bit_cnt;

  logic [7:0] rx_next;
  logic       cnt_full;

  assign rx_next  = {rx_sr[6:0], mosi_lvl};
  assign cnt_full = (bit_cnt == JSTK_CNT_W'(JSTK_FRAME_BITS));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= ST_IDLE;
      tx_sr       <= '0;
      rx_sr       <= '0;
      bit_cnt     <= '0;
      MISO        <= 1'b0;
      Led         <= 2'b00;
      Cmd_Valid   <= 1'b0;
      Frame_Done  <= 1'b0;
      Frame_Error <= 1'b0;
    end else begin
      Cmd_Valid   <= 1'b0;
      Frame_Done  <= 1'b0;
      Frame_Error <= 1'b0;
      case (state)
        ST_IDLE: begin
          MISO <= 1'b0;
          // The snapshot is taken on the SS-fall strobe so bit 39 is on
          // MISO one cycle after the strobe; LOAD then masks any SCLK
          // edge that arrives alongside SS fall.
          if (ss_fall) begin
            tx_sr   <= jstk_pack_frame(X_Pos, Y_Pos, Buttons);
            MISO    <= X_Pos[7];
            bit_cnt <= '0;
            rx_sr   <= '0;
            state   <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (ss_rise) begin
            Frame_Error <= 1'b1;
            MISO        <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            state <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (ss_rise) begin
            Frame_Done  <= cnt_full;
            Frame_Error <= ~cnt_full;
            MISO        <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            if (sclk_rise && !cnt_full) begin
              rx_sr   <= rx_next;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == JSTK_CNT_W'(7) && rx_next[7:2] == JSTK_CMD_PREFIX) begin
                Led       <= rx_next[1:0];
                Cmd_Valid <= 1'b1;
              end
            end
            if (sclk_fall) begin
              tx_sr <= {tx_sr[JSTK_FRAME_BITS-2:0], 1'b0};
              MISO  <= cnt_full ? 1'b0 : tx_sr[JSTK_FRAME_BITS-2];
            end
          end
        end

        default: begin
          MISO  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/jstk_spi_responder.md
# jstk_spi_responder

SPI responder that emulates the PmodJSTK joystick on the slave side of the 5-byte joystick transfer. It sits on the opposite end of the link from the joystick SPI master. It serves two purposes: a bench model for the game's joystick path, and a synthesizable joystick source when one board drives another's port JA. It snapshots the X/Y positions and button state at frame start, shifts them out on MISO, and captures the LED command from the master's first byte.

## Interface
- `SCLK_MAX_DIV`, default 8: minimum Clk cycles per SCLK half-period that is guaranteed to work. Documentation only; used by the bench.
- `Clk`  in  1  system clock (board clock, 100 MHz).
- `Reset`  in  1  asynchronous, active-high reset.
- `SS`  in  1  slave select from master, active low, asynchronous to Clk.
- `SCLK`  in  1  serial clock from master, asynchronous to Clk.
- `MOSI`  in  1  master-out data.
- `MISO`  out  1  slave-out data, MSB first.
- `X_Pos`  in  10  joystick X position, 0..1023.
- `Y_Pos`  in  10  joystick Y position, 0..1023.
- `Buttons`  in  3  {btn2, btn1 (trigger), btn0}.
- `Led`  out  2  LED bits from the last valid command byte.
- `Cmd_Valid`  out  1  one-cycle pulse when a command byte `100000LL` is latched.
- `Frame_Done`  out  1  one-cycle pulse after all 40 bits are transferred and SS rises.
- `Frame_Error`  out  1  one-cycle pulse when SS rises with bit count ≠ 40.

## Operation
- SS, SCLK and MOSI each pass through a 2-flop synchronizer, then a third stage for edge detection. SS fall, SCLK rise and SCLK fall are single-cycle strobes.
- SPI mode 0:
  - The master samples MISO on SCLK rise.
  - The responder samples MOSI on SCLK rise and updates MISO on SCLK fall.
- States:
  - IDLE: MISO=0. On SS fall, go to LOAD.
  - LOAD (1 cycle): latch a 40-bit shift register with {X_Pos[7:0], 6'b0, X_Pos[9:8], Y_Pos[7:0], 6'b0, Y_Pos[9:8], 5'b0, Buttons}. Drive MISO = bit 39. Clear the 6-bit bit counter. Go to SHIFT.
  - SHIFT:
    - SCLK rise: shift MOSI into an 8-bit receive register and increment the bit counter.
    - SCLK fall: left-shift the transmit register and drive the new MSB. After bit 40, MISO=0.
    - When the bit counter reaches 8, check the receive register. If rx[7:2]==6'b100000, latch Led=rx[1:0] and pulse Cmd_Valid. Otherwise leave Led unchanged.
    - SS rise: if the count is 40, pulse Frame_Done; otherwise pulse Frame_Error. Go to IDLE.
- SCLK edges beyond 40 are ignored (the counter saturates at 40). SS rise after more than 40 edges still signals Frame_Done.
- Position and button inputs are sampled only in LOAD. Changes mid-frame affect the next frame only.
- If SS fall and SCLK rise are detected in the same cycle, LOAD takes priority and that SCLK edge is discarded. The master must not do this.
- Reset mid-frame returns to IDLE immediately. A new frame starts only on the next SS fall.

## Timing
- Reset values: MISO=0, Led=2'b00, Cmd_Valid=0, Frame_Done=0, Frame_Error=0, state IDLE.
- Edge-strobe latency: 3 Clk cycles from the pin edge.
- MISO bit 39 is valid 4 Clk cycles after SS falls. Each later bit is valid 4 Clk cycles after SCLK falls.
- The master must leave at least `SCLK_MAX_DIV` Clk cycles:
  - between SS fall and the first SCLK rise;
  - in each SCLK half-period.
  The in-game master (about 1 MHz SCLK, 10 µs gaps) satisfies this with a large margin.
- Cmd_Valid asserts 4 cycles after the 8th SCLK rise.
- Frame_Done and Frame_Error assert 4 cycles after SS rises.

## Structure
- Shared package constants:
  - JSTK_FRAME_BITS = 40
  - JSTK_CMD_PREFIX = 6'b100000
  - state encodings IDLE/LOAD/SHIFT
  - byte field offsets (X_LO=39, X_HI=31, Y_LO=23, Y_HI=15, BTN=7)
- One natural sub-module: `sync_edge_detect` (2-flop synchronizer plus rise/fall strobes), instantiated three times with asynchronous reset to the idle level (SS=1, SCLK=0, MOSI=0).

## Test plan
- Normal frame: X=10'h2A5, Y=10'h17F, Buttons=3'b010, master sends 8'h83 then 4×8'h00 at Clk/50 → master reads bytes A5,02,7F,01,02; Led=2'b11; one Cmd_Valid; one Frame_Done; no Frame_Error.
- Bad command: first byte 8'h41 → Led keeps its prior value, no Cmd_Valid, data bytes still correct, Frame_Done pulses.
- Short frame: SS rises after 17 SCLK edges → Frame_Error pulses once, no Frame_Done. The next full frame with X=0, Y=10'h3FF, Buttons=7 returns 00,00,FF,03,07.
- Mid-frame input change: X changes from 10'h001 to 10'h3FF after bit 3 → this frame reports 01,00. The next frame reports FF,03.
- Reset mid-frame after 20 bits → MISO=0, Led=0, no pulses. A subsequent complete frame succeeds.
- Overrun: 48 SCLK edges → bits 41–48 read 0 and Frame_Done pulses.
